// File: rtl/pong_pkg.sv
// Shared encodings and playfield constants for the Pong match controller.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE   = 2'b00,
        WIN_PLAYER = 2'b01,
        WIN_COM    = 2'b10
    } winner_t;

    localparam int FIELD_W       = 20;
    localparam int FIELD_H       = 15;
    localparam int DEF_WIN_SCORE = 9;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_match_sequencer_if.sv
// Bus between the match sequencer, the ball/paddle datapath and the renderer.
interface pong_match_sequencer_if;
    logic [4:0] BALL_X;
    logic       STEP_EN;
    logic       BALL_RESET;
    logic [3:0] SCORE_P;
    logic [3:0] SCORE_C;
    logic [2:0] STATE;
    logic [1:0] WINNER;
    logic       PAUSED;

    modport master (
        input  BALL_X,
        output STEP_EN, BALL_RESET, SCORE_P, SCORE_C, STATE, WINNER, PAUSED
    );

    modport slave (
        output BALL_X,
        input  STEP_EN, BALL_RESET, SCORE_P, SCORE_C, STATE, WINNER, PAUSED
    );
endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an active-low button plus a registered press pulse
// on the falling edge; the press appears two edges after the pin is sampled low.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic last_q,  last_d;
    logic press_q, press_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        last_d  = sync2_q;
        press_d = last_q & ~sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            last_q  <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            last_q  <= last_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/pong_match_sequencer.sv
// Match controller: game-tick prescaler, serve/play/point/over sequencing,
// goal detection, score keeping and pause handling for the Pong datapath.
module pong_match_sequencer
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 2500000,
    parameter int W           = FIELD_W,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int SERVE_TICKS = 20,
    parameter int POINT_TICKS = 10
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START_N,
    input  logic                   PAUSE_N,
    pong_match_sequencer_if.master bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(imax(SERVE_TICKS, POINT_TICKS) + 1);

    logic [1:0] btn_n;
    logic [1:0] press;
    logic       start_press;
    logic       pause_press;

    assign btn_n = {PAUSE_N, START_N};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_sync_edge u_btn (
            .clk   (CLK),
            .rst_n (RST_N),
            .btn_n (btn_n[gi]),
            .press (press[gi])
        );
    end

    assign start_press = press[0];
    assign pause_press = press[1];

    state_t          state_q,     state_d;
    logic [3:0]      score_p_q,   score_p_d;
    logic [3:0]      score_c_q,   score_c_d;
    winner_t         winner_q,    winner_d;
    logic            paused_q,    paused_d;
    logic            step_en_q,   step_en_d;
    logic            ball_reset_q, ball_reset_d;
    logic [PW-1:0]   presc_q,     presc_d;
    logic [TW-1:0]   timer_q,     timer_d;

    logic       tick;
    logic       tick_run;
    logic       goal_left;
    logic       goal_right;
    logic       goal;
    logic       paused_nx;
    logic       hold;
    logic [3:0] inc_p;
    logic [3:0] inc_c;

    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign goal_left  = (state_q == ST_PLAY) && !paused_q && (bus.BALL_X == 5'd0);
    assign goal_right = (state_q == ST_PLAY) && !paused_q && (bus.BALL_X == 5'(W - 1));
    assign goal       = goal_left | goal_right;
    assign inc_p      = sat_inc4(score_p_q);
    assign inc_c      = sat_inc4(score_c_q);

    // A goal in the same cycle swallows the pause press.
    always_comb begin
        paused_nx = paused_q;
        if (pause_press && !goal &&
            (state_q == ST_SERVE || state_q == ST_PLAY || state_q == ST_POINT)) begin
            paused_nx = !paused_q;
        end
    end

    // Freeze from the toggle cycle through the un-toggle cycle so the tick
    // phase is preserved exactly across a pause.
    assign hold     = paused_q | paused_nx;
    assign tick_run = tick & ~hold;

    always_comb begin
        state_d      = state_q;
        score_p_d    = score_p_q;
        score_c_d    = score_c_q;
        winner_d     = winner_q;
        timer_d      = timer_q;
        ball_reset_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    score_p_d    = 4'd0;
                    score_c_d    = 4'd0;
                    winner_d     = WIN_NONE;
                    ball_reset_d = 1'b1;
                    state_d      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tick_run) begin
                    if (timer_q == TW'(SERVE_TICKS - 1)) state_d = ST_PLAY;
                    else                                 timer_d = timer_q + TW'(1);
                end
            end
            ST_PLAY: begin
                if (goal_left) begin
                    score_c_d = inc_c;
                    if (inc_c == 4'(WIN_SCORE)) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_COM;
                    end else begin
                        state_d  = ST_POINT;
                    end
                end else if (goal_right) begin
                    score_p_d = inc_p;
                    if (inc_p == 4'(WIN_SCORE)) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_PLAYER;
                    end else begin
                        state_d  = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (tick_run) begin
                    if (timer_q == TW'(POINT_TICKS - 1)) begin
                        ball_reset_d = 1'b1;
                        state_d      = ST_SERVE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_press) begin
                    score_p_d = 4'd0;
                    score_c_d = 4'd0;
                    winner_d  = WIN_NONE;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) timer_d = '0;
    end

    // Every phase starts with a full tick period.
    always_comb begin
        if (state_d != state_q) presc_d = '0;
        else if (hold)          presc_d = presc_q;
        else if (tick)          presc_d = '0;
        else                    presc_d = presc_q + PW'(1);

        paused_d  = (state_d == ST_IDLE || state_d == ST_OVER) ? 1'b0 : paused_nx;
        step_en_d = tick_run && (state_q == ST_PLAY) && (state_d == ST_PLAY);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            score_p_q    <= 4'd0;
            score_c_q    <= 4'd0;
            winner_q     <= WIN_NONE;
            paused_q     <= 1'b0;
            step_en_q    <= 1'b0;
            ball_reset_q <= 1'b0;
            presc_q      <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            score_p_q    <= score_p_d;
            score_c_q    <= score_c_d;
            winner_q     <= winner_d;
            paused_q     <= paused_d;
            step_en_q    <= step_en_d;
            ball_reset_q <= ball_reset_d;
            presc_q      <= presc_d;
            timer_q      <= timer_d;
        end
    end

    assign bus.STEP_EN    = step_en_q;
    assign bus.BALL_RESET = ball_reset_q;
    assign bus.SCORE_P    = score_p_q;
    assign bus.SCORE_C    = score_c_q;
    assign bus.STATE      = state_q;
    assign bus.WINNER     = winner_q;
    assign bus.PAUSED     = paused_q;
endmodule

// File: doc/pong_match_sequencer.md
Name: pong_match_sequencer

Overview:
Match-level controller for the Pong game datapath. It divides the system clock into game ticks and issues one step enable per tick to the ball/paddle datapath, but only while a rally is live. It detects goals from the ball X position, keeps both scores, and runs the serve countdown, post-point freeze, pause and game-over sequencing. It sits between the board buttons/clock and the game datapath; score and state outputs feed the VGA renderer.

Parameters:
TICK_DIV, 2500000, CLK cycles per game tick (25 MHz -> 10 Hz); legal range >= 2
W, 20, playfield width in cells; goal columns are 0 and W-1
WIN_SCORE, 9, points needed to win; legal range 1..15
SERVE_TICKS, 20, ticks spent in SERVE before the ball moves; >= 1
POINT_TICKS, 10, ticks the field freezes after a goal; >= 1

Ports:
CLK  in  1  system clock; the single clock of the block
RST_N  in  1  reset, asynchronous assert, active-low
START_N  in  1  raw start button, active-low, already debounced
PAUSE_N  in  1  raw pause button, active-low, already debounced
BALL_X  in  5  current ball column from the game datapath
STEP_EN  out  1  one-CLK pulse; the datapath advances one game step
BALL_RESET  out  1  one-CLK pulse; the datapath recentres the ball
SCORE_P  out  4  player score (left side)
SCORE_C  out  4  com score (right side)
STATE  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
WINNER  out  2  00 none, 01 player, 10 com
PAUSED  out  1  pause flag

Behaviour:
- Reset (async, RST_N=0): STATE=IDLE; SCORE_P, SCORE_C, WINNER, STEP_EN, BALL_RESET, PAUSED, prescaler and phase timer all 0. Synchronizer flops reset to 1 (button released). Applying reset mid-match discards the match.
- Buttons: each button passes through a 2-FF synchronizer and a falling-edge detector, giving a 1-CLK press pulse. Latency: a button sampled low at edge k produces its effect at edge k+3.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the single cycle where count==TICK_DIV-1. The prescaler holds its value while PAUSED=1. It resets to 0 on every state entry, so each phase starts with a full tick period.
- STEP_EN = tick AND (STATE==PLAY) AND NOT PAUSED. It is registered, so the pulse appears one cycle after tick.
- IDLE: on a start press, clear both scores, clear WINNER, pulse BALL_RESET, and go to SERVE.
- SERVE: the phase timer counts ticks. When the timer reaches SERVE_TICKS, go to PLAY.
- PLAY: the goal check runs every cycle while not paused.
  - BALL_X==0 gives SCORE_C+1.
  - BALL_X==W-1 gives SCORE_P+1.
  - Both scores use saturating 4-bit arithmetic.
  - After a goal, go to OVER if the incremented score equals WIN_SCORE, otherwise go to POINT.
  - Only one goal can be counted per PLAY visit.
- POINT: after POINT_TICKS ticks, pulse BALL_RESET and go to SERVE. BALL_X is not checked outside PLAY, so a stale goal column never double-counts.
- OVER: set WINNER to the side that reached WIN_SCORE. Scores are held and STEP_EN stays 0. A start press goes to IDLE and clears the scores.
- Pause: a pause press toggles PAUSED only in SERVE, PLAY or POINT. PAUSED is forced to 0 on entry to IDLE or OVER. While paused, the timer and prescaler freeze and no goal is evaluated.
- Simultaneous events:
  - A goal and a pause press in the same cycle: the goal wins and the pause press is dropped.
  - A start press outside IDLE/OVER is ignored.
  - A start press and a pause press in the same cycle in IDLE: start is taken and pause is ignored.
- BALL_RESET and STEP_EN are never high in the same cycle.

Decomposition:
- Package pong_pkg holds:
  - the state codes IDLE..OVER;
  - the WINNER codes;
  - the playfield constants W=20, H=15, default WIN_SCORE.
- Timer width is derived as clog2(max(SERVE_TICKS,POINT_TICKS)+1).
- One sub-module, btn_sync_edge: a 2-FF synchronizer plus falling-edge pulse with async active-low reset. It is instanced for START_N and PAUSE_N.

Test Plan:
All scenarios use TICK_DIV=4, SERVE_TICKS=2, POINT_TICKS=1, WIN_SCORE=3.
1. Hold reset, release, idle for 100 CLK -> STATE=0, scores 0, no STEP_EN or BALL_RESET pulses.
2. Press START_N (low at edge k) -> BALL_RESET high exactly at edge k+3 for 1 cycle, STATE=1; PLAY after 8 CLK; then STEP_EN once every 4 CLK.
3. In PLAY drive BALL_X=0 -> SCORE_C=1 next cycle, STATE=3, STEP_EN stops; after 4 CLK BALL_RESET pulses, STATE=1.
4. Score three goals with BALL_X=19 -> SCORE_P=3, STATE=4, WINNER=01, STEP_EN stays 0 for 100 CLK; press START -> STATE=0, scores 0, WINNER=00.
5. Press PAUSE_N mid-PLAY with prescaler at 2 -> PAUSED=1, no STEP_EN for 50 CLK and BALL_X=0 ignored; press again -> first STEP_EN 2 CLK after PAUSED falls.
6. Assert RST_N low mid-PLAY with SCORE_P=2 -> same cycle (async) STATE=0, scores 0, PAUSED=0, no pulse after release.
